character_jump_ctrl: RTL and testbench
======================================

// Module: character_jump_ctrl
// PURPOSE
//  Sequences the player character's hop between the 9 platform columns of the 800x600 playfield.
//  Accepts left/right jump requests and runs a frame-paced rise/fall arc.
//  Produces xpos/ypos for the character's draw_rect stage (top-left corner, pixels).
//  Also produces column index, busy and landed status for game logic.
// PARAMETERS
//  N_COLS      9    number of platform columns, indices 0..N_COLS-1
//  START_COL   4    column after reset
//  COL_W       80   column pitch in pixels
//  X_BASE      40   xpos of column 0
//  Y_GROUND    500  ypos when standing
//  HALF_FRAMES 8    frames per half-arc (rise = fall = HALF_FRAMES)
//  STEP_X      5    x pixels per frame; must equal COL_W/(2*HALF_FRAMES)
//  STEP_Y      12   y pixels per frame; peak height = STEP_Y*HALF_FRAMES
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   synchronous reset, active-high
//  enable     in   1   0 = freeze: ignore frame_tick and requests
//  frame_tick in   1   1-cycle pulse once per frame, arc advance strobe
//  jump_left  in   1   request hop to col-1 (level, sampled each clk)
//  jump_right in   1   request hop to col+1
//  xpos       out  10  character x, 0..799
//  ypos       out  10  character y, 0..599
//  col        out  4   current (landed) column
//  busy       out  1   1 while in RISE/FALL/LAND
//  landed     out  1   1-cycle pulse on arc completion
// BEHAVIOUR
//  Reset: state=IDLE, col=START_COL, xpos=X_BASE+START_COL*COL_W (360), ypos=Y_GROUND (500),
//   busy=0, landed=0, frame counter=0, direction=0. All outputs are registered.
//  States: IDLE -> RISE -> FALL -> LAND -> IDLE.
//  IDLE, enable=1: requests are sampled on every clk (not only on frame_tick).
//   - Exactly one of jump_left/jump_right high and target col in range: latch dir, cnt=0,
//     go to RISE; busy=1 on the next cycle.
//   - Both high, target <0 or >N_COLS-1: request ignored, stay IDLE.
//  RISE, on each frame_tick: ypos-=STEP_Y, xpos+=/-STEP_X, cnt++.
//   - Tick with cnt==HALF_FRAMES-1: apply the step, cnt=0, go to FALL.
//  FALL, on each frame_tick: ypos+=STEP_Y, xpos+=/-STEP_X, cnt++.
//   - On the last tick: ypos==Y_GROUND, xpos==X_BASE+target*COL_W exactly, col=target, go to LAND.
//  LAND: landed=1 for exactly one cycle; next state is IDLE (or RISE, see CONFIGURATION).
//  enable=0 in any state: state, counters and outputs hold; frame_ticks are lost, not deferred.
//  frame_tick in IDLE has no effect. No arithmetic wrap: legal targets keep xpos within 40..680.
//  rst mid-arc: takes priority over everything; next cycle shows reset values.
// CONFIGURATION
//  JUMP_BUFFER_EN defined:
//   - One-entry request buffer, filled by a legal single-direction request seen while busy.
//   - Legality is checked against the pending target; the latest request overwrites the buffer.
//   - In LAND with the buffer valid: landed still pulses, the state goes directly to RISE with the
//     buffered dir, and the buffer clears.
//   - rst clears the buffer.
//  JUMP_BUFFER_EN undefined: requests while busy are dropped; no buffer logic is built.
// TESTING (defaults)
//  1. rst 1 cycle -> xpos=360, ypos=500, col=4, busy=0, landed=0.
//  2. jump_right 1 clk, 16 frame_ticks -> after tick 8: xpos=400, ypos=404;
//     after tick 16: xpos=440, ypos=500, col=5, one landed pulse, busy=0.
//  3. Reach col 8, then jump_right -> ignored, busy stays 0;
//     jump_left+jump_right in the same clk -> ignored.
//  4. enable=0 for 5 ticks mid-RISE -> xpos/ypos frozen; landing needs 16 ticks counted with enable=1.
//  5. rst at tick 6 of an arc -> next cycle xpos=360, ypos=500, col=4, busy=0.
//  6. jump_right, then jump_left during RISE:
//     - JUMP_BUFFER_EN: landed pulse, immediate RISE, final col=4.
//     - Undefined: final col=5, busy=0.

Source files
------------

// File: rtl/character_jump_ctrl.sv
// character_jump_ctrl: sequences the player's hop between platform columns.
// A left/right request launches a frame-paced arc (rise then fall), after
// which the character lands exactly on the neighbouring column.
// Optional feature macro: JUMP_BUFFER_EN (one-entry buffer for a request
// made while a hop is still in progress).
module character_jump_ctrl #(
    parameter int N_COLS      = 9,
    parameter int START_COL   = 4,
    parameter int COL_W       = 80,
    parameter int X_BASE      = 40,
    parameter int Y_GROUND    = 500,
    parameter int HALF_FRAMES = 8,
    parameter int STEP_X      = 5,
    parameter int STEP_Y      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       jump_left,
    input  logic       jump_right,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [3:0] col,
    output logic       busy,
    output logic       landed
);

    localparam int CNT_W = (HALF_FRAMES > 1) ? $clog2(HALF_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HALF_FRAMES - 1);
    localparam logic [3:0]       LAST_COL   = 4'(N_COLS - 1);
    localparam logic [3:0]       START_C    = 4'(START_COL);
    localparam logic [9:0]       X_BASE_L   = 10'(X_BASE);
    localparam logic [9:0]       COL_W_L    = 10'(COL_W);
    localparam logic [9:0]       Y_GROUND_L = 10'(Y_GROUND);
    localparam logic [9:0]       STEP_X_L   = 10'(STEP_X);
    localparam logic [9:0]       STEP_Y_L   = 10'(STEP_Y);
    localparam logic [9:0]       X_START    = 10'(X_BASE + START_COL * COL_W);

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        LAND
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       col_q, col_d;
    logic [9:0]       xpos_q, xpos_d;
    logic [9:0]       ypos_q, ypos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;      // 1 = moving left, 0 = moving right
    logic             busy_q, busy_d;
    logic             landed_q, landed_d;

    logic             req_one;
    logic             req_legal;
    logic [3:0]       target_col;
    logic [9:0]       x_step;

`ifdef JUMP_BUFFER_EN
    logic             buf_valid_q, buf_valid_d;
    logic             buf_dir_q, buf_dir_d;
    logic [3:0]       pend_col;
    logic             buf_legal;
`endif

    // Request decode, arc target and the horizontal step for the current hop
    always_comb begin
        req_one    = jump_left ^ jump_right;
        req_legal  = jump_left ? (col_q != 4'd0) : (col_q != LAST_COL);
        target_col = dir_q ? (col_q - 4'd1) : (col_q + 4'd1);
        x_step     = dir_q ? (xpos_q - STEP_X_L) : (xpos_q + STEP_X_L);
    end

    // Next-state logic for the hop sequencer and all registered outputs
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
`ifdef JUMP_BUFFER_EN
        buf_valid_d = buf_valid_q;
        buf_dir_d   = buf_dir_q;
        // While busy, legality is judged from where the current hop ends
        pend_col    = (state_q == LAND) ? col_q : target_col;
        buf_legal   = jump_left ? (pend_col != 4'd0) : (pend_col != LAST_COL);
        if (enable && (state_q != IDLE) && req_one && buf_legal) begin
            buf_valid_d = 1'b1;
            buf_dir_d   = jump_left;
        end
`endif
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (req_one && req_legal) begin
                        state_d = RISE;
                        dir_d   = jump_left;
                        cnt_d   = '0;
                    end
                end
                RISE: begin
                    if (frame_tick) begin
                        ypos_d = ypos_q - STEP_Y_L;
                        xpos_d = x_step;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = FALL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (frame_tick) begin
                        if (cnt_q == CNT_LAST) begin
                            // Snap to the exact landing spot so no rounding drift accumulates
                            ypos_d  = Y_GROUND_L;
                            xpos_d  = X_BASE_L + 10'(target_col) * COL_W_L;
                            col_d   = target_col;
                            cnt_d   = '0;
                            state_d = LAND;
                        end else begin
                            ypos_d = ypos_q + STEP_Y_L;
                            xpos_d = x_step;
                            cnt_d  = cnt_q + 1'b1;
                        end
                    end
                end
                LAND: begin
                    state_d = IDLE;
`ifdef JUMP_BUFFER_EN
                    if (buf_valid_d) begin
                        state_d     = RISE;
                        dir_d       = buf_dir_d;
                        cnt_d       = '0;
                        buf_valid_d = 1'b0;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d   = (state_d != IDLE);
        landed_d = (state_d == LAND);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= START_C;
            xpos_q   <= X_START;
            ypos_q   <= Y_GROUND_L;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            landed_q <= landed_d;
        end
    end

`ifdef JUMP_BUFFER_EN
    // Buffered request register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_dir_q   <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_dir_q   <= buf_dir_d;
        end
    end
`endif

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign col    = col_q;
    assign busy   = busy_q;
    assign landed = landed_q;

endmodule

// File: tb/tb_character_jump_ctrl.sv
// Testbench for character_jump_ctrl: vector table, directed corner-case
// sequences and randomized traffic checked against a frame-count model.
module tb_character_jump_ctrl;

    localparam int N_COLS   = 9;
    localparam int START    = 4;
    localparam int COL_W    = 80;
    localparam int X_BASE   = 40;
    localparam int Y_GROUND = 500;
    localparam int H        = 8;
    localparam int STEP_X   = 5;
    localparam int STEP_Y   = 12;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       frame_tick;
    logic       jump_left;
    logic       jump_right;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [3:0] col;
    logic       busy;
    logic       landed;

    int testsRun;
    int testsFailed;

    // Model state: phase 0 = standing, 1 = in the air, 2 = landing cycle
    int mPhase;
    int mCol;
    int mFrames;
    int mDir;
`ifdef JUMP_BUFFER_EN
    int mBufValid;
    int mBufDir;
`endif

    typedef struct {
        logic r;
        logic en;
        logic tick;
        logic jl;
        logic jr;
        int   reps;
        int   ex;
        int   ey;
        int   ecol;
        logic ebusy;
        logic elanded;
    } vec_t;

    vec_t vecs[14];

    character_jump_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_tick (frame_tick),
        .jump_left  (jump_left),
        .jump_right (jump_right),
        .xpos       (xpos),
        .ypos       (ypos),
        .col        (col),
        .busy       (busy),
        .landed     (landed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic r, input logic en, input logic tick,
                                   input logic jl, input logic jr, input int reps,
                                   input int ex, input int ey, input int ecol,
                                   input logic ebusy, input logic elanded);
        vec_t v;
        v.r = r; v.en = en; v.tick = tick; v.jl = jl; v.jr = jr; v.reps = reps;
        v.ex = ex; v.ey = ey; v.ecol = ecol; v.ebusy = ebusy; v.elanded = elanded;
        return v;
    endfunction

    // Behavioural model: position derived from column, direction and frames flown
    task automatic modelUpdate(input logic r, input logic e, input logic t,
                               input logic jl, input logic jr);
        int tgt;
        if (r) begin
            mPhase = 0; mCol = START; mFrames = 0; mDir = 1;
`ifdef JUMP_BUFFER_EN
            mBufValid = 0; mBufDir = 1;
`endif
        end else if (e) begin
`ifdef JUMP_BUFFER_EN
            if (mPhase != 0 && (jl ^ jr)) begin
                tgt = ((mPhase == 1) ? mCol + mDir : mCol) + (jl ? -1 : 1);
                if (tgt >= 0 && tgt < N_COLS) begin
                    mBufValid = 1;
                    mBufDir   = jl ? -1 : 1;
                end
            end
`endif
            case (mPhase)
                0: begin
                    tgt = mCol + (jl ? -1 : 1);
                    if ((jl ^ jr) && tgt >= 0 && tgt < N_COLS) begin
                        mPhase = 1; mFrames = 0; mDir = jl ? -1 : 1;
                    end
                end
                1: begin
                    if (t) begin
                        mFrames++;
                        if (mFrames == 2 * H) begin
                            mCol += mDir; mFrames = 0; mPhase = 2;
                        end
                    end
                end
                default: begin
                    mPhase = 0;
`ifdef JUMP_BUFFER_EN
                    if (mBufValid != 0) begin
                        mPhase = 1; mDir = mBufDir; mFrames = 0; mBufValid = 0;
                    end
`endif
                end
            endcase
        end
    endtask

    // Drive one clock of inputs, then advance the model with the same inputs
    task automatic applyStimulus(input logic r, input logic e, input logic t,
                                 input logic jl, input logic jr);
        rst = r; enable = e; frame_tick = t; jump_left = jl; jump_right = jr;
        @(posedge clk);
        #1;
        modelUpdate(r, e, t, jl, jr);
        rst = 1'b0; frame_tick = 1'b0; jump_left = 1'b0; jump_right = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int ex, input int ey, input int ecol,
                               input logic ebusy, input logic elanded);
        testsRun++;
        if (int'(xpos) != ex || int'(ypos) != ey || int'(col) != ecol ||
            busy !== ebusy || landed !== elanded) begin
            testsFailed++;
            $display("[TB] FAIL %s: got x=%0d y=%0d col=%0d busy=%b landed=%b, want x=%0d y=%0d col=%0d busy=%b landed=%b",
                     name, xpos, ypos, col, busy, landed, ex, ey, ecol, ebusy, elanded);
        end
    endtask

    task automatic checkModel(input string name);
        int ex, ey, lift;
        ex = X_BASE + mCol * COL_W;
        ey = Y_GROUND;
        if (mPhase == 1) begin
            ex += mDir * STEP_X * mFrames;
            lift = (mFrames <= H) ? mFrames : (2 * H - mFrames);
            ey -= STEP_Y * lift;
        end
        checkOutput(name, ex, ey, mCol, (mPhase != 0), (mPhase == 2));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        rst = 1'b0; enable = 1'b1; frame_tick = 1'b0; jump_left = 1'b0; jump_right = 1'b0;
        mPhase = 0; mCol = START; mFrames = 0; mDir = 1;
`ifdef JUMP_BUFFER_EN
        mBufValid = 0; mBufDir = 1;
`endif
        @(negedge clk);

        // Vector table: reset, right hop, idle corner cases, left hop with freeze
        vecs[0]  = mkVec(1, 1, 0, 0, 0, 1, 360, 500, 4, 0, 0);
        vecs[1]  = mkVec(0, 1, 0, 0, 1, 1, 360, 500, 4, 1, 0);
        vecs[2]  = mkVec(0, 1, 1, 0, 0, 8, 400, 404, 4, 1, 0);
        vecs[3]  = mkVec(0, 1, 1, 0, 0, 8, 440, 500, 5, 1, 1);
        vecs[4]  = mkVec(0, 1, 0, 0, 0, 1, 440, 500, 5, 0, 0);
        vecs[5]  = mkVec(0, 1, 0, 1, 1, 1, 440, 500, 5, 0, 0);
        vecs[6]  = mkVec(0, 1, 1, 0, 0, 3, 440, 500, 5, 0, 0);
        vecs[7]  = mkVec(0, 1, 0, 1, 0, 1, 440, 500, 5, 1, 0);
        vecs[8]  = mkVec(0, 1, 1, 0, 0, 3, 425, 464, 5, 1, 0);
        vecs[9]  = mkVec(0, 0, 1, 0, 0, 5, 425, 464, 5, 1, 0);
        vecs[10] = mkVec(0, 0, 0, 0, 1, 2, 425, 464, 5, 1, 0);
        vecs[11] = mkVec(0, 1, 1, 0, 0, 5, 400, 404, 5, 1, 0);
        vecs[12] = mkVec(0, 1, 1, 0, 0, 8, 360, 500, 4, 1, 1);
        vecs[13] = mkVec(0, 1, 0, 0, 0, 1, 360, 500, 4, 0, 0);

        for (int v = 0; v < 14; v++) begin
            for (int k = 0; k < vecs[v].reps; k++)
                applyStimulus(vecs[v].r, vecs[v].en, vecs[v].tick, vecs[v].jl, vecs[v].jr);
            checkOutput($sformatf("vec%0d", v), vecs[v].ex, vecs[v].ey, vecs[v].ecol,
                        vecs[v].ebusy, vecs[v].elanded);
        end

        // Hop right to the last column, then try to go beyond it
        for (int h = 0; h < 4; h++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            ticks(16);
            checkOutput($sformatf("hop%0d_land", h), 40 + (5 + h) * 80, 500, 5 + h, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("edge_right_ignored", 680, 500, 8, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("edge_both_ignored", 680, 500, 8, 1'b0, 1'b0);

        // Reset in the middle of an arc
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(6);
        checkOutput("arc_tick6", 390, 428, 4, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("midarc_reset", 360, 500, 4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("after_reset_idle", 360, 500, 4, 1'b0, 1'b0);

        // Opposite request during RISE
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        ticks(13);
        checkOutput("late_req_land", 440, 500, 5, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef JUMP_BUFFER_EN
        checkOutput("buffered_rise", 440, 500, 5, 1'b1, 1'b0);
        ticks(16);
        checkOutput("buffered_land", 360, 500, 4, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("buffered_idle", 360, 500, 4, 1'b0, 1'b0);
`else
        checkOutput("dropped_req_idle", 440, 500, 5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("dropped_req_stays", 440, 500, 5, 1'b0, 1'b0);
`endif

        // Randomized traffic against the model
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkModel("rand_reset");
        for (int c = 0; c < 4000; c++) begin
            applyStimulus(($urandom % 700) == 0, ($urandom % 8) != 0, ($urandom % 3) == 0,
                          ($urandom % 5) == 0, ($urandom % 5) == 0);
            checkModel($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
